dac_slot_fifo: RTL

- Byte FIFO that sits directly upstream of a slot DAC module and feeds it.
- The host/FX2 side pushes sample bytes. The DAC side pops them with `fifo_read` strobes. These strobes arrive in short bursts after each rising edge of `fifo_clk`, which the DAC generates.
- Exposes write and read pointers as `fifo_addr_in` / `fifo_addr_out`, plus level, flags and burst statistics.
- Single clock domain, 2048 x 8 storage by default.

---
 rtl/dac_slot_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dac_slot_fifo.sv
// dac_slot_fifo: byte FIFO with first-word-fall-through head feeding the slot DAC.
// Define DAC_SLOT_FIFO_PREFILL_EN to hold pops until PREFILL_LEVEL bytes are queued.
module dac_slot_fifo #(
  parameter int ADDR_WIDTH         = 11,
  parameter int DATA_WIDTH         = 8,
  parameter int ALMOST_FULL_MARGIN = 16,
  parameter int PREFILL_LEVEL      = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic                  clear_flags,
  input  logic                  fifo_clk,
  input  logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic [ADDR_WIDTH-1:0] fifo_addr_in,
  output logic [ADDR_WIDTH-1:0] fifo_addr_out,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           burst_count
);

  localparam int Depth = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem [Depth];

  ptr_t wptr;
  ptr_t rptr;
  ptr_t free_space;
  logic fifo_clk_q;
  logic primed;
  logic push_ok;
  logic push_err;
  logic pop_ok;
  logic pop_err;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                 (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

  assign free_space  = ptr_t'(Depth) - level;
  assign almost_full = (free_space <= ptr_t'(ALMOST_FULL_MARGIN));

  assign fifo_addr_in  = wptr[ADDR_WIDTH-1:0];
  assign fifo_addr_out = rptr[ADDR_WIDTH-1:0];

  // Flush swallows every push/pop, including would-be error events.
  assign push_ok  = wr_en & ~full & ~flush;
  assign push_err = wr_en & full & ~flush;
  assign pop_ok   = fifo_read & primed & ~empty & ~flush;
  assign pop_err  = fifo_read & primed & empty & ~flush;

  assign fifo_data = (primed && !empty) ?
                     mem[rptr[ADDR_WIDTH-1:0]] : '0;

`ifdef DAC_SLOT_FIFO_PREFILL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed <= 1'b0;
    end else if (flush) begin
      primed <= 1'b0;
    end else if (level >= ptr_t'(PREFILL_LEVEL)) begin
      primed <= 1'b1;
    end
  end
`else
  // Without priming the head is always live.
  assign primed = (PREFILL_LEVEL >= 0);
`endif

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level <= level + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level <= level - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_err) begin
        overflow <= 1'b1;
      end else if (clear_flags) begin
        overflow <= 1'b0;
      end
      if (pop_err) begin
        underflow <= 1'b1;
      end else if (clear_flags) begin
        underflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_clk_q  <= 1'b0;
      burst_count <= '0;
    end else begin
      fifo_clk_q <= fifo_clk;
      if (fifo_clk && !fifo_clk_q) begin
        burst_count <= burst_count + 16'd1;
      end
    end
  end

endmodule
